// File: rtl/clock_ui_pkg.sv
// Shared encodings for the front-panel controller: mode/field codes,
// button indices and the inc/dec auto-repeat state machine.
package clock_ui_pkg;

  localparam logic [1:0] MODE_CLOCK     = 2'd0;
  localparam logic [1:0] MODE_ALARM     = 2'd1;
  localparam logic [1:0] MODE_TIMER     = 2'd2;
  localparam logic [1:0] MODE_STOPWATCH = 2'd3;

  localparam logic [1:0] SEL_SEC  = 2'd0;
  localparam logic [1:0] SEL_MIN  = 2'd1;
  localparam logic [1:0] SEL_HOUR = 2'd2;
  localparam logic [1:0] SEL_DAY  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    HOLD   = 2'd2,
    REPEAT = 2'd3
  } rpt_state_e;

  // Both the mode and field buses are 2-bit rings that wrap 3 -> 0.
  function automatic logic [1:0] next_wrap2(input logic [1:0] value);
    return value + 2'd1;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// One push-button: 2-flop synchronizer, counting debouncer and a
// registered rising-edge press pulse.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          primed_q;
  logic          primed_d;
  logic          press_q;
  logic          press_d;

  // The synchronizer is deliberately not reset so that a button held through
  // reset is still seen as held afterwards and cannot fake a fresh press.
  always_ff @(posedge clk) begin
    sync1_q <= raw;
    sync2_q <= sync1_q;
  end

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    primed_d = primed_q | ~sync2_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d    = '0;
      stable_d = sync2_q;
      press_d  = sync2_q & primed_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // A press only counts once the button has been seen released since reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      primed_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
      press_q  <= press_d;
    end
  end

  assign level = stable_q;
  assign press = press_q;

endmodule

// File: rtl/clock_ui_controller.sv
// Front-panel controller: button conditioning, mode/field sequencing,
// inc/dec auto-repeat strobes, start/stop strobe and the muted beeper.
module clock_ui_controller
  import clock_ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_RATE     = 100,
  parameter int BEEP_HALF       = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_select,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_startstop,
  input  logic       timer_buzzer,
  output logic [1:0] mode,
  output logic [1:0] selected,
  output logic       increment,
  output logic       decrement,
  output logic       startstop,
  output logic       buzzer_out
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(RPT_MAX);
  localparam int BW      = $clog2(BEEP_HALF + 1);
  localparam logic [RW-1:0] RPT_DELAY_LOAD = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_RATE_LOAD  = RW'(REPEAT_RATE - 1);
  localparam logic [BW-1:0] BEEP_LAST      = BW'(BEEP_HALF - 1);

  logic mode_lvl, mode_prs;
  logic sel_lvl, sel_prs;
  logic inc_lvl, inc_prs;
  logic dec_lvl, dec_prs;
  logic ss_lvl, ss_prs;
  logic unused_levels;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_mode (
    .clk(clk), .reset(reset), .raw(btn_mode), .level(mode_lvl), .press(mode_prs)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_select (
    .clk(clk), .reset(reset), .raw(btn_select), .level(sel_lvl), .press(sel_prs)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_inc (
    .clk(clk), .reset(reset), .raw(btn_inc), .level(inc_lvl), .press(inc_prs)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_dec (
    .clk(clk), .reset(reset), .raw(btn_dec), .level(dec_lvl), .press(dec_prs)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_startstop (
    .clk(clk), .reset(reset), .raw(btn_startstop), .level(ss_lvl), .press(ss_prs)
  );

  assign unused_levels = ^{mode_lvl, sel_lvl, ss_lvl};

  logic [1:0]    mode_q, mode_d;
  logic [1:0]    sel_q, sel_d;
  logic          ss_q;
  logic          inc_q, inc_d;
  logic          dec_q, dec_d;
  rpt_state_e    state_q, state_d;
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          dir_inc_q, dir_inc_d;
  logic          both_high;
  logic          held;
  logic          abort;
  logic          strobe;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic          beep_off_q, beep_off_d;
  logic          mute_q, mute_d;
  logic          buz_q, buz_d;

  // A mode press wins over a simultaneous select press and clears the field.
  always_comb begin
    mode_d = mode_q;
    sel_d  = sel_q;
    if (mode_prs) begin
      mode_d = next_wrap2(mode_q);
      sel_d  = SEL_SEC;
    end else if (sel_prs) begin
      sel_d = next_wrap2(sel_q);
    end
  end

  assign both_high = inc_lvl & dec_lvl;
  assign held      = dir_inc_q ? inc_lvl : dec_lvl;
  assign abort     = both_high | ~held | mode_prs;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rpt_cnt_q <= '0;
      dir_inc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
      dir_inc_q <= dir_inc_d;
    end
  end

  // Only a fresh press starts a sequence, so a button left held after an
  // abort stays silent until it is released and pressed again.
  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    dir_inc_d = dir_inc_q;
    unique case (state_q)
      IDLE: begin
        if (inc_prs && !dec_lvl) begin
          state_d   = FIRST;
          dir_inc_d = 1'b1;
        end else if (dec_prs && !inc_lvl) begin
          state_d   = FIRST;
          dir_inc_d = 1'b0;
        end
      end
      FIRST: begin
        if (both_high) begin
          state_d = IDLE;
        end else begin
          state_d   = HOLD;
          rpt_cnt_d = RPT_DELAY_LOAD;
        end
      end
      HOLD, REPEAT: begin
        if (abort) begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == '0) begin
          state_d   = REPEAT;
          rpt_cnt_d = RPT_RATE_LOAD;
        end else begin
          rpt_cnt_d = rpt_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    strobe = 1'b0;
    unique case (state_q)
      FIRST:        strobe = ~both_high;
      HOLD, REPEAT: strobe = ~abort & (rpt_cnt_q == '0);
      default:      strobe = 1'b0;
    endcase
    inc_d = strobe & dir_inc_q;
    dec_d = strobe & ~dir_inc_q;
  end

  // Beep phase starts audible; dropping the request resets phase and mute.
  always_comb begin
    beep_cnt_d = beep_cnt_q;
    beep_off_d = beep_off_q;
    mute_d     = mute_q;
    if (timer_buzzer) begin
      if (beep_cnt_q == BEEP_LAST) begin
        beep_cnt_d = '0;
        beep_off_d = ~beep_off_q;
      end else begin
        beep_cnt_d = beep_cnt_q + 1'b1;
      end
      if (ss_prs && buz_q) begin
        mute_d = 1'b1;
      end
    end else begin
      beep_cnt_d = '0;
      beep_off_d = 1'b0;
      mute_d     = 1'b0;
    end
    buz_d = timer_buzzer & ~beep_off_q & ~mute_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= MODE_CLOCK;
      sel_q      <= SEL_SEC;
      ss_q       <= 1'b0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      beep_cnt_q <= '0;
      beep_off_q <= 1'b0;
      mute_q     <= 1'b0;
      buz_q      <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      sel_q      <= sel_d;
      ss_q       <= ss_prs;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      beep_cnt_q <= beep_cnt_d;
      beep_off_q <= beep_off_d;
      mute_q     <= mute_d;
      buz_q      <= buz_d;
    end
  end

  assign mode       = mode_q;
  assign selected   = sel_q;
  assign increment  = inc_q;
  assign decrement  = dec_q;
  assign startstop  = ss_q;
  assign buzzer_out = buz_q;

endmodule

// File: tb/tb_clock_ui_controller.sv
// Directed bench for clock_ui_controller with short debounce/repeat/beep
// timings; expected strobe cycles are counted from the raw button edge.
module tb_clock_ui_controller;

  localparam int DEB   = 4;
  localparam int RDLY  = 10;
  localparam int RRATE = 3;
  localparam int BHALF = 2;

  localparam int B_MODE = 0;
  localparam int B_SEL  = 1;
  localparam int B_INC  = 2;
  localparam int B_DEC  = 3;
  localparam int B_SS   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       btnMode, btnSelect, btnInc, btnDec, btnStartstop;
  logic       timerBuzzer;
  logic [1:0] mode, selected;
  logic       increment, decrement, startstop, buzzerOut;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  clock_ui_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_RATE    (RRATE),
    .BEEP_HALF      (BHALF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_mode     (btnMode),
    .btn_select   (btnSelect),
    .btn_inc      (btnInc),
    .btn_dec      (btnDec),
    .btn_startstop(btnStartstop),
    .timer_buzzer (timerBuzzer),
    .mode         (mode),
    .selected     (selected),
    .increment    (increment),
    .decrement    (decrement),
    .startstop    (startstop),
    .buzzer_out   (buzzerOut)
  );

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic setButton(input int which, input logic value);
    case (which)
      B_MODE:  btnMode      = value;
      B_SEL:   btnSelect    = value;
      B_INC:   btnInc       = value;
      B_DEC:   btnDec       = value;
      default: btnStartstop = value;
    endcase
  endtask

  task automatic applyStimulus(input int which, input int holdSteps, input int gapSteps);
    setButton(which, 1'b1);
    step(holdSteps);
    setButton(which, 1'b0);
    step(gapSteps);
  endtask

  // Step i is checked first, then the raw inputs scheduled for i change.
  task automatic watchWindow(input string tag, input int nSteps,
                             input int incOffAt, input int decOnAt, input int decOffAt,
                             input int modeOnAt, input int modeOffAt,
                             input logic [63:0] expInc, input logic [63:0] expDec);
    for (int i = 1; i <= nSteps; i++) begin
      step(1);
      checkOutput({tag, " increment"}, increment, expInc[i]);
      checkOutput({tag, " decrement"}, decrement, expDec[i]);
      if (i == incOffAt)  btnInc  = 1'b0;
      if (i == decOnAt)   btnDec  = 1'b1;
      if (i == decOffAt)  btnDec  = 1'b0;
      if (i == modeOnAt)  btnMode = 1'b1;
      if (i == modeOffAt) btnMode = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [63:0] expInc;
    logic [63:0] expDec;
    int          strobeCount;
    logic        expBuz;

    reset        = 1'b1;
    btnMode      = 1'b0;
    btnSelect    = 1'b0;
    btnInc       = 1'b0;
    btnDec       = 1'b0;
    btnStartstop = 1'b0;
    timerBuzzer  = 1'b0;
    step(3);
    checkOutput("reset mode", mode, 0);
    checkOutput("reset selected", selected, 0);
    checkOutput("reset increment", increment, 0);
    checkOutput("reset decrement", decrement, 0);
    checkOutput("reset startstop", startstop, 0);
    checkOutput("reset buzzer", buzzerOut, 0);
    reset = 1'b0;
    step(2);

    // First mode press: pulse exactly DEB+3 edges after the raw rise.
    btnMode = 1'b1;
    step(6);
    checkOutput("mode press early", dut.u_btn_mode.press, 0);
    step(1);
    checkOutput("mode press at +7", dut.u_btn_mode.press, 1);
    checkOutput("mode before update", mode, 0);
    step(1);
    checkOutput("mode after press", mode, 1);
    checkOutput("mode press one cycle", dut.u_btn_mode.press, 0);
    checkOutput("selected after mode", selected, 0);
    step(12);
    btnMode = 1'b0;
    step(10);
    checkOutput("mode held gives one step", mode, 1);
    for (int k = 2; k <= 4; k++) begin
      applyStimulus(B_MODE, 10, 10);
      checkOutput("mode sequence", mode, k % 4);
    end

    // Field selection and the mode-clears-field rule.
    applyStimulus(B_SEL, 10, 10);
    applyStimulus(B_SEL, 10, 10);
    checkOutput("selected after two", selected, 2);
    btnMode = 1'b1;
    step(7);
    checkOutput("mode pre-edge", mode, 0);
    checkOutput("selected pre-edge", selected, 2);
    step(1);
    checkOutput("mode clears field: mode", mode, 1);
    checkOutput("mode clears field: selected", selected, 0);
    step(5);
    btnMode = 1'b0;
    step(10);
    applyStimulus(B_SEL, 10, 10);
    checkOutput("selected after one", selected, 1);
    btnMode   = 1'b1;
    btnSelect = 1'b1;
    step(8);
    checkOutput("mode+select: mode", mode, 2);
    checkOutput("mode+select: selected", selected, 0);
    step(5);
    btnMode   = 1'b0;
    btnSelect = 1'b0;
    step(10);

    // Three-cycle glitch on inc must be filtered out.
    btnInc = 1'b1;
    step(3);
    btnInc = 1'b0;
    strobeCount = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (increment) strobeCount++;
    end
    checkOutput("glitch strobes", strobeCount, 0);
    checkOutput("glitch level", dut.u_btn_inc.level, 0);

    // Inc held: strobes at 9, then 19 and every 3 until release lands at 47.
    expInc = '0;
    expDec = '0;
    expInc[9] = 1'b1;
    for (int s = 19; s <= 46; s += 3) expInc[s] = 1'b1;
    btnInc = 1'b1;
    watchWindow("inc hold", 60, 40, -1, -1, -1, -1, expInc, expDec);
    step(5);

    // Dec held: same timing on the decrement output only.
    expInc = '0;
    expDec = '0;
    expDec[9]  = 1'b1;
    expDec[19] = 1'b1;
    expDec[22] = 1'b1;
    expDec[25] = 1'b1;
    btnDec = 1'b1;
    watchWindow("dec hold", 30, -1, -1, 20, -1, -1, expInc, expDec);
    step(5);

    // Dec joins a held inc: strobes stop, and releasing dec does not restart.
    expInc = '0;
    expDec = '0;
    expInc[9]  = 1'b1;
    expInc[19] = 1'b1;
    btnInc = 1'b1;
    watchWindow("inc then dec", 60, 50, 13, 30, -1, -1, expInc, expDec);
    step(5);

    expInc = '0;
    expInc[9] = 1'b1;
    btnInc = 1'b1;
    watchWindow("inc repress", 20, 10, -1, -1, -1, -1, expInc, expDec);
    step(5);

    // Mode press mid-repeat ends the sequence at once.
    expInc = '0;
    expInc[9]  = 1'b1;
    expInc[19] = 1'b1;
    expInc[22] = 1'b1;
    expInc[25] = 1'b1;
    btnInc = 1'b1;
    watchWindow("mode abort", 55, 45, -1, -1, 19, 29, expInc, expDec);
    step(5);
    checkOutput("mode after abort press", mode, 3);

    // Beeper pattern 1,1,0,0 and mute from a start/stop press while sounding.
    timerBuzzer = 1'b1;
    for (int s = 1; s <= 25; s++) begin
      step(1);
      expBuz = (s <= 14) ? (((s - 1) % 4) < 2) : 1'b0;
      checkOutput("buzzer pattern", buzzerOut, expBuz);
      checkOutput("startstop strobe", startstop, s == 14);
      if (s == 6)  btnStartstop = 1'b1;
      if (s == 20) btnStartstop = 1'b0;
    end
    timerBuzzer = 1'b0;
    step(1);
    checkOutput("buzzer off", buzzerOut, 0);
    step(3);
    timerBuzzer = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      step(1);
      checkOutput("buzzer resumes", buzzerOut, ((s - 1) % 4) < 2);
    end
    timerBuzzer = 1'b0;
    step(3);

    // Reset during REPEAT with inc held.
    btnInc = 1'b1;
    step(25);
    checkOutput("repeat before reset", increment, 1);
    reset = 1'b1;
    step(1);
    checkOutput("mid reset increment", increment, 0);
    checkOutput("mid reset decrement", decrement, 0);
    checkOutput("mid reset mode", mode, 0);
    checkOutput("mid reset selected", selected, 0);
    checkOutput("mid reset startstop", startstop, 0);
    checkOutput("mid reset buzzer", buzzerOut, 0);
    step(2);
    reset = 1'b0;
    strobeCount = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (increment) strobeCount++;
    end
    checkOutput("held through reset strobes", strobeCount, 0);
    btnInc = 1'b0;
    step(10);
    expInc = '0;
    expInc[9] = 1'b1;
    btnInc = 1'b1;
    watchWindow("repress after reset", 20, 10, -1, -1, -1, -1, expInc, expDec);
    step(5);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
